// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
// The op encoding follows RV32M funct3 order.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    logic [2:0] v;
    v = op;
    return v[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  // rs1 is treated as signed for every op except the fully unsigned ones
  function automatic logic a_is_signed(input muldiv_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic b_is_signed(input muldiv_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_prep.sv
// Accept-path operand conditioning: magnitudes, result sign and the RISC-V
// special cases (divide by zero, signed overflow) that bypass the iteration.
module muldiv_sign_prep
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] a_mag_o,
  output logic [XLEN-1:0] b_mag_o,
  output logic            neg_o,
  output logic            special_o,
  output logic [XLEN-1:0] special_res_o
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_op_t op;
  logic       a_neg;
  logic       b_neg;
  logic       div_zero;
  logic       div_ovf;

  assign op    = muldiv_op_t'(op_i);
  assign a_neg = a_is_signed(op) && a_i[XLEN-1];
  assign b_neg = b_is_signed(op) && b_i[XLEN-1];

  // The most negative value negates to itself, which is still the correct
  // unsigned magnitude.
  assign a_mag_o = a_neg ? -a_i : a_i;
  assign b_mag_o = b_neg ? -b_i : b_i;

  // Remainder takes the dividend sign; everything else is the sign product.
  assign neg_o = is_rem(op) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = is_div(op) && (b_i == '0);
  assign div_ovf  = ((op == MD_DIV) || (op == MD_REM)) &&
                    (a_i == MIN_NEG) && (b_i == '1);

  assign special_o = div_zero || div_ovf;

  always_comb begin
    special_res_o = '0;
    if (div_zero) begin
      special_res_o = is_rem(op) ? a_i : '1;
    end else if (div_ovf) begin
      special_res_o = is_rem(op) ? '0 : a_i;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative XLEN-wide multiply/divide unit, one bit per cycle, with
// valid/ready handshakes on issue and result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int            CW       = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  muldiv_state_t     state_q;
  logic [CW-1:0]     count_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opd_q;
  logic [XLEN-1:0]   result_q;
  muldiv_op_t        op_q;
  logic              neg_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  muldiv_op_t      op_in;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            prep_neg;
  logic            prep_special;
  logic [XLEN-1:0] prep_special_res;

  assign op_in = muldiv_op_t'(op);

  muldiv_sign_prep #(
    .XLEN (XLEN)
  ) u_sign_prep (
    .op_i          (op),
    .a_i           (a),
    .b_i           (b),
    .a_mag_o       (a_mag),
    .b_mag_o       (b_mag),
    .neg_o         (prep_neg),
    .special_o     (prep_special),
    .special_res_o (prep_special_res)
  );

  // Multiply: acc = {partial high, multiplier being shifted out}; add-then-shift.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: acc = {partial remainder, dividend shifting into quotient}.
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;

  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opd_q};
  assign div_ge    = ~div_diff[XLEN];
  assign div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};

  logic [2*XLEN-1:0] acc_d;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   result_d;

  assign acc_d = is_div(op_q) ? div_next : mul_next;

  // Sign fix-up on the final step; MUL low word is sign-agnostic so negating
  // the full product serves every multiply variant.
  assign prod_fix = neg_q ? -acc_d : acc_d;
  assign quo_fix  = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
  assign rem_fix  = neg_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];

  always_comb begin
    result_d = '0;
    case (op_q)
      MD_MUL:                       result_d = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result_d = quo_fix;
      MD_REM, MD_REMU:              result_d = rem_fix;
      default:                      result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      opd_q       <= '0;
      op_q        <= MD_MUL;
      neg_q       <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      // result_q is deliberately kept: a kill only drops the handshake
      state_q     <= IDLE;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q       <= op_in;
            neg_q      <= prep_neg;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            count_q    <= '0;
            if (prep_special) begin
              result_q    <= prep_special_res;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              acc_q   <= {{XLEN{1'b0}}, (is_div(op_in) ? a_mag : b_mag)};
              opd_q   <= is_div(op_in) ? b_mag : a_mag;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          if (count_q == CNT_LAST) begin
            count_q     <= '0;
            result_q    <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          count_q     <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule
